// File: rtl/sky_xu_pkg.sv
// Shared Skylark XU definitions: register-file geometry and the writeback request record.
package sky_xu_pkg;

   localparam int NUM_REGS   = 16;
   localparam int REG_ADDR_W = 4;
   localparam int XLEN       = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   localparam int WB_REQ_W = $bits(wb_req_t);

endpackage

// File: rtl/sky_wb_fifo.sv
// Generic synchronous first-word-fall-through FIFO with occupancy count and full/empty flags.
module sky_wb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 36,
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == CW'(0));
   assign count     = count_r;
   assign pop_data  = mem_r[rd_ptr_r];
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;

   // Payload storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= PW'(0);
         rd_ptr_r <= PW'(0);
         count_r  <= CW'(0);
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/sky_writeback_unit.sv
// Writeback stage: arbitrates ALU results and buffered load results onto the single
// register-file write port and tracks which registers still have loads in flight.
module sky_writeback_unit
   import sky_xu_pkg::*;
#(
   parameter int LD_FIFO_DEPTH = 4,
   parameter int STARVE_LIMIT  = 3,
   localparam int CW           = $clog2(LD_FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [REG_ADDR_W-1:0] ld_rd,
   input  logic [XLEN-1:0]       ld_data,
   output logic                  wb_enable,
   output logic [REG_ADDR_W-1:0] wb_addr,
   output logic [XLEN-1:0]       wb_data,
   output logic [NUM_REGS-1:0]   pending_mask,
   output logic [CW-1:0]         fifo_count
);

   wb_req_t       push_req_s;
   wb_req_t       head_s;
   logic          fifo_full_s;
   logic          fifo_empty_s;
   logic          alu_fire_s;
   logic          push_s;
   logic          pop_s;
   logic [3:0]    starve_cnt_r;
   logic [CW-1:0] pend_cnt_r  [NUM_REGS];
   logic [CW-1:0] pend_next_s [NUM_REGS];

   // Both readies come from flops only, so producers never see a combinational path.
   assign ld_ready   = !fifo_full_s;
   assign alu_ready  = !(!fifo_empty_s && (starve_cnt_r == 4'(STARVE_LIMIT)));
   assign alu_fire_s = alu_valid && alu_ready;
   assign push_s     = ld_valid && ld_ready && (ld_rd != REG_ADDR_W'(0));
   assign pop_s      = !fifo_empty_s && !alu_fire_s;
   assign push_req_s = '{rd: ld_rd, data: ld_data};

   sky_wb_fifo #(
      .DEPTH (LD_FIFO_DEPTH),
      .WIDTH (WB_REQ_W)
   ) u_ld_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data (push_req_s),
      .pop       (pop_s),
      .pop_data  (head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count)
   );

   // Registered write port; rd==0 ALU results are consumed silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_enable <= 1'b0;
         wb_addr   <= REG_ADDR_W'(0);
         wb_data   <= XLEN'(0);
      end else if (alu_fire_s) begin
         wb_enable <= (alu_rd != REG_ADDR_W'(0));
         if (alu_rd != REG_ADDR_W'(0)) begin
            wb_addr <= alu_rd;
            wb_data <= alu_data;
         end
      end else if (pop_s) begin
         wb_enable <= 1'b1;
         wb_addr   <= head_s.rd;
         wb_data   <= head_s.data;
      end else begin
         wb_enable <= 1'b0;
      end
   end

   // Starvation counter: counts ALU wins over a waiting load, saturating at the limit.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_r <= 4'd0;
      end else if (fifo_empty_s || pop_s) begin
         starve_cnt_r <= 4'd0;
      end else if (alu_fire_s && (starve_cnt_r != 4'(STARVE_LIMIT))) begin
         starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end

   // Per-register in-flight load counts; enqueue and dequeue of the same rd cancel out.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         pend_next_s[r] = pend_cnt_r[r]
                        + {{(CW-1){1'b0}}, (push_s && (ld_rd == REG_ADDR_W'(r)))}
                        - {{(CW-1){1'b0}}, (pop_s && (head_s.rd == REG_ADDR_W'(r)))};
      end
   end

   // Pending counters update on the same edge that issues the load write.
   always_ff @(posedge clk) begin
      for (int r = 0; r < NUM_REGS; r++) begin
         if (reset) begin
            pend_cnt_r[r] <= CW'(0);
         end else begin
            pend_cnt_r[r] <= pend_next_s[r];
         end
      end
   end

   // Mask bit per register derived from its in-flight counter.
   always_comb begin
      pending_mask = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         pending_mask[r] = (pend_cnt_r[r] != CW'(0));
      end
   end

endmodule

// File: tb/tb_sky_writeback_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_sky_writeback_unit;

   localparam int DEPTH = 4;
   localparam int LIMIT = 3;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          alu_valid;
   logic          alu_ready;
   logic [3:0]    alu_rd;
   logic [31:0]   alu_data;
   logic          ld_valid;
   logic          ld_ready;
   logic [3:0]    ld_rd;
   logic [31:0]   ld_data;
   logic          wb_enable;
   logic [3:0]    wb_addr;
   logic [31:0]   wb_data;
   logic [15:0]   pending_mask;
   logic [CW-1:0] fifo_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sky_writeback_unit #(
      .LD_FIFO_DEPTH (DEPTH),
      .STARVE_LIMIT  (LIMIT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_rd        (ld_rd),
      .ld_data      (ld_data),
      .wb_enable    (wb_enable),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .pending_mask (pending_mask),
      .fifo_count   (fifo_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: an ordered queue of loads, per-register in-flight counts.
   typedef struct {
      logic [3:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];
   int          mpend[16];
   int          mstarve;
   logic        m_en;
   logic [3:0]  m_addr;
   logic [31:0] m_data;
   bit          a_fired;
   bit          l_fired;

   function automatic bit m_alu_rdy();
      return !((mq.size() > 0) && (mstarve == LIMIT));
   endfunction

   function automatic bit m_ld_rdy();
      return (mq.size() < DEPTH);
   endfunction

   task automatic compare_all(input string tag);
      logic [15:0] emask;
      emask = 16'h0000;
      for (int r = 0; r < 16; r++) emask[r] = (mpend[r] != 0);
      check({tag, ".wb_enable"}, 32'(wb_enable), 32'(m_en));
      check({tag, ".wb_addr"}, 32'(wb_addr), 32'(m_addr));
      check({tag, ".wb_data"}, wb_data, m_data);
      check({tag, ".pending_mask"}, 32'(pending_mask), 32'(emask));
      check({tag, ".fifo_count"}, 32'(fifo_count), 32'(mq.size()));
      check({tag, ".alu_ready"}, 32'(alu_ready), 32'(m_alu_rdy()));
      check({tag, ".ld_ready"}, 32'(ld_ready), 32'(m_ld_rdy()));
   endtask

   // One clock: drive at the falling edge, advance the model, compare after the next rising edge.
   task automatic cycle(input string tag, input bit rst,
                        input bit av, input logic [3:0] ard, input logic [31:0] adat,
                        input bit lv, input logic [3:0] lrd, input logic [31:0] ldat);
      reset     = rst;
      alu_valid = av;
      alu_rd    = ard;
      alu_data  = adat;
      ld_valid  = lv;
      ld_rd     = lrd;
      ld_data   = ldat;
      if (rst) begin
         mq.delete();
         for (int r = 0; r < 16; r++) mpend[r] = 0;
         mstarve = 0;
         m_en    = 1'b0;
         m_addr  = 4'd0;
         m_data  = 32'd0;
         a_fired = 1'b0;
         l_fired = 1'b0;
      end else begin
         bit ne;
         bit pop;
         ne      = (mq.size() > 0);
         a_fired = av && m_alu_rdy();
         l_fired = lv && m_ld_rdy();
         pop     = ne && !a_fired;
         if (a_fired) begin
            m_en = (ard != 4'd0);
            if (ard != 4'd0) begin
               m_addr = ard;
               m_data = adat;
            end
         end else if (pop) begin
            m_en   = 1'b1;
            m_addr = mq[0].rd;
            m_data = mq[0].data;
         end else begin
            m_en = 1'b0;
         end
         if (!ne || pop) mstarve = 0;
         else if (a_fired && mstarve < LIMIT) mstarve++;
         if (pop) begin
            mpend[mq[0].rd]--;
            void'(mq.pop_front());
         end
         if (l_fired && lrd != 4'd0) begin
            mq.push_back('{lrd, ldat});
            mpend[lrd]++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      compare_all(tag);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle("idle", 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
   endtask

   bit          cav, clv;
   logic [3:0]  card, clrd;
   logic [31:0] cadat, cldat;
   int          alu_pct;

   initial begin
      reset = 1'b1;
      alu_valid = 1'b0; alu_rd = 4'd0; alu_data = 32'd0;
      ld_valid = 1'b0;  ld_rd = 4'd0;  ld_data = 32'd0;
      @(negedge clk);
      cycle("reset", 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      cycle("reset", 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      check("rst_wb_enable", 32'(wb_enable), 32'd0);
      check("rst_alu_ready", 32'(alu_ready), 32'd1);
      check("rst_ld_ready", 32'(ld_ready), 32'd1);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);

      // ALU only, then rd==0 produces no write
      cycle("t1", 1'b0, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
      check("t1_en", 32'(wb_enable), 32'd1);
      check("t1_addr", 32'(wb_addr), 32'd5);
      check("t1_data", wb_data, 32'hDEADBEEF);
      cycle("t1z", 1'b0, 1'b1, 4'd0, 32'h11111111, 1'b0, 4'd0, 32'd0);
      check("t1_rd0_no_write", 32'(wb_enable), 32'd0);

      // Load only: pending after enqueue, cleared with the write
      cycle("t2", 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'h1234);
      check("t2_pend_set", 32'(pending_mask[7]), 32'd1);
      check("t2_no_write_yet", 32'(wb_enable), 32'd0);
      cycle("t2w", 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      check("t2_en", 32'(wb_enable), 32'd1);
      check("t2_addr", 32'(wb_addr), 32'd7);
      check("t2_data", wb_data, 32'h1234);
      check("t2_pend_clr", 32'(pending_mask[7]), 32'd0);

      // FIFO full with ALU saturating the port
      for (int k = 1; k <= 4; k++)
         cycle("t3", 1'b0, 1'b1, 4'(k), 32'(k), 1'b1, 4'(k + 8), 32'hA000 + 32'(k));
      check("t3_count_full", 32'(fifo_count), 32'd4);
      check("t3_ld_ready_low", 32'(ld_ready), 32'd0);
      l_fired = 1'b0;
      for (int k = 0; k < 8 && !l_fired; k++)
         cycle("t3h", 1'b0, 1'b1, 4'd2, 32'h22, 1'b1, 4'd13, 32'hA005);
      check("t3_ld5_accepted", 32'(l_fired), 32'd1);
      idle(8);

      // Starvation: ALU wins LIMIT times, then the load is forced through
      cycle("t4", 1'b0, 1'b1, 4'd1, 32'h1, 1'b1, 4'd3, 32'h3333);
      for (int k = 0; k < LIMIT; k++) cycle("t4a", 1'b0, 1'b1, 4'd1, 32'h100 + 32'(k), 1'b0, 4'd0, 32'd0);
      check("t4_alu_blocked", 32'(alu_ready), 32'd0);
      cycle("t4l", 1'b0, 1'b1, 4'd1, 32'h200, 1'b0, 4'd0, 32'd0);
      check("t4_load_addr", 32'(wb_addr), 32'd3);
      check("t4_alu_reopened", 32'(alu_ready), 32'd1);
      idle(2);

      // Duplicate rd keeps the mask bit until the second write
      cycle("t5", 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 32'h9001);
      cycle("t5", 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 32'h9002);
      check("t5_pend_still", 32'(pending_mask[9]), 32'd1);
      cycle("t5", 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      check("t5_second_data", wb_data, 32'h9002);
      check("t5_pend_clr", 32'(pending_mask[9]), 32'd0);

      // Reset with three loads queued
      for (int k = 0; k < 3; k++) cycle("t6", 1'b0, 1'b1, 4'd4, 32'h44, 1'b1, 4'(k + 10), 32'hB0 + 32'(k));
      cycle("t6r", 1'b1, 1'b1, 4'd4, 32'h44, 1'b1, 4'd12, 32'hBB);
      check("t6_count", 32'(fifo_count), 32'd0);
      check("t6_mask", 32'(pending_mask), 32'd0);
      check("t6_en", 32'(wb_enable), 32'd0);
      idle(4);

      // Randomized traffic honouring the hold-while-stalled rule
      cav = 1'b0; clv = 1'b0; card = 4'd0; clrd = 4'd0; cadat = 32'd0; cldat = 32'd0;
      for (int i = 0; i < 4000; i++) begin
         alu_pct = ((i / 400) % 2 == 0) ? 90 : 40;
         if (!(cav && !a_fired)) begin
            cav   = ($urandom_range(0, 99) < alu_pct);
            card  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            cadat = $urandom;
         end
         if (!(clv && !l_fired)) begin
            clv   = ($urandom_range(0, 99) < 60);
            clrd  = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            cldat = $urandom;
         end
         if ($urandom_range(0, 299) == 0) begin
            cycle("rnd_rst", 1'b1, cav, card, cadat, clv, clrd, cldat);
            cav = 1'b0;
            clv = 1'b0;
         end else begin
            cycle("rnd", 1'b0, cav, card, cadat, clv, clrd, cldat);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
